br_resolve_unit: RTL and testbench

Parametrised, elastic branch-resolution unit for the out-of-order core. It accepts one issued control-flow instruction per cycle from the branch reservation station and resolves JAL/JALR/conditional branches against the front-end prediction, including the predicted target. It drives a valid/ready result port toward the CDB arbiter after a configurable pipeline depth. It squashes younger in-flight entries on external kill/flush or on its own mispredict, and keeps saturating performance counters.

---
 rtl/br_resolve_unit.sv | 186 ++++++++++++++++++
 tb/tb_br_resolve_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_unit.sv
// Elastic branch-resolution unit: resolves JAL/JALR/BR at issue, carries the result
// through DEPTH stages to a valid/ready port, squashes by ROB age, and counts outcomes.
module br_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned PHYS_W    = 6,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [PHYS_W-1:0]    in_rd_phys,
  input  logic [4:0]           in_rd_arch,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_rs1_v,
  input  logic [XLEN-1:0]      in_rs2_v,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 in_pred_taken,
  input  logic [XLEN-1:0]      in_pred_target,
  input  logic [ROB_IDX_W-1:0] rob_head,
  input  logic                 kill_valid,
  input  logic [ROB_IDX_W-1:0] kill_rob_idx,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [PHYS_W-1:0]    out_rd_phys,
  output logic [4:0]           out_rd_arch,
  output logic [XLEN-1:0]      out_data,
  output logic                 out_taken,
  output logic                 out_miss,
  output logic [XLEN-1:0]      out_target,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     cnt_resolved,
  output logic [CNT_W-1:0]     cnt_miss,
  output logic [CNT_W-1:0]     cnt_tgt_miss
);

  localparam int unsigned LAST    = DEPTH - 1;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [6:0]  OP_BR   = 7'b1100011;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [PHYS_W-1:0]    phys;
    logic [4:0]           arch;
    logic [XLEN-1:0]      data;
    logic                 taken;
    logic                 miss;
    logic [XLEN-1:0]      target;
    logic                 pred;
  } stage_t;

  logic [DEPTH-1:0]     r_v;
  stage_t               r_st [DEPTH];
  logic [CNT_W-1:0]     r_cnt_res, r_cnt_miss, r_cnt_tgt;

  logic                 w_is_jal, w_is_jalr, w_is_br, w_is_jump, w_cond;
  logic [XLEN-1:0]      w_pc4, w_br_tgt, w_jalr_sum;
  stage_t               w_res;
  logic                 w_hs, w_self, w_kill_in;
  logic [ROB_IDX_W-1:0] w_kage, w_sage;
  logic [DEPTH-1:0]     w_free, w_kill, w_src_v;
  stage_t               w_src [DEPTH];

  function automatic logic [ROB_IDX_W-1:0] f_age(input logic [ROB_IDX_W-1:0] x,
                                                 input logic [ROB_IDX_W-1:0] head);
    return x - head;
  endfunction

  always_comb begin
    w_is_jal   = (in_opcode == OP_JAL);
    w_is_jalr  = (in_opcode == OP_JALR);
    w_is_br    = (in_opcode == OP_BR);
    w_is_jump  = w_is_jal || w_is_jalr || w_is_br;
    w_pc4      = in_pc + XLEN'(4);
    w_br_tgt   = in_pc + in_imm;
    w_jalr_sum = in_rs1_v + in_imm;
    w_cond     = 1'b0;
    case (in_funct3)
      3'b000:  w_cond = (in_rs1_v == in_rs2_v);
      3'b001:  w_cond = (in_rs1_v != in_rs2_v);
      3'b100:  w_cond = ($signed(in_rs1_v) <  $signed(in_rs2_v));
      3'b101:  w_cond = ($signed(in_rs1_v) >= $signed(in_rs2_v));
      3'b110:  w_cond = (in_rs1_v <  in_rs2_v);
      3'b111:  w_cond = (in_rs1_v >= in_rs2_v);
      default: w_cond = 1'b0;
    endcase

    w_res      = '0;
    w_res.rob  = in_rob_idx;
    w_res.phys = in_rd_phys;
    w_res.arch = in_rd_arch;
    w_res.pred = in_pred_taken;
    if (w_is_jal || w_is_jalr) begin
      w_res.taken  = 1'b1;
      w_res.target = w_is_jal ? w_br_tgt : {w_jalr_sum[XLEN-1:1], 1'b0};
      w_res.data   = w_pc4;
      w_res.miss   = !in_pred_taken || (in_pred_target != w_res.target);
    end else if (w_is_br) begin
      w_res.taken  = w_cond;
      w_res.target = w_cond ? w_br_tgt : w_pc4;
      w_res.miss   = (w_cond != in_pred_taken) || (w_cond && (in_pred_target != w_res.target));
    end
  end

  // A stage can take new content when it is empty or some stage at/after it frees up;
  // squash refs are evaluated against the same-cycle handshake so kills land at this edge.
  always_comb begin
    w_hs      = r_v[LAST] && out_ready;
    w_self    = w_hs && r_st[LAST].miss;
    w_kage    = f_age(kill_rob_idx, rob_head);
    w_sage    = f_age(r_st[LAST].rob, rob_head);
    w_kill_in = flush
             || (kill_valid && (f_age(in_rob_idx, rob_head) > w_kage))
             || (w_self && (f_age(in_rob_idx, rob_head) > w_sage));
    w_kill  = '0;
    w_free  = '0;
    w_src_v = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_src[k]  = r_st[k];
      w_kill[k] = flush
               || (kill_valid && (f_age(r_st[k].rob, rob_head) > w_kage))
               || (w_self && (f_age(r_st[k].rob, rob_head) > w_sage));
      w_free[k] = out_ready;
      for (int unsigned j = k; j < DEPTH; j++) begin
        if (!r_v[j]) w_free[k] = 1'b1;
      end
    end
    w_src[0]   = w_res;
    w_src_v[0] = in_valid && w_is_jump && !w_kill_in;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      w_src_v[k] = r_v[k-1] && !w_kill[k-1];
      w_src[k]   = r_st[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) r_st[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_free[k]) begin
          r_v[k] <= w_src_v[k];
          if (w_src_v[k]) r_st[k] <= w_src[k];
        end else begin
          r_v[k] <= r_v[k] && !w_kill[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || cnt_clear) begin
      r_cnt_res  <= '0;
      r_cnt_miss <= '0;
      r_cnt_tgt  <= '0;
    end else if (w_hs) begin
      if (r_cnt_res != '1) r_cnt_res <= r_cnt_res + CNT_W'(1);
      if (r_st[LAST].miss && (r_cnt_miss != '1)) r_cnt_miss <= r_cnt_miss + CNT_W'(1);
      if (r_st[LAST].miss && r_st[LAST].taken && r_st[LAST].pred && (r_cnt_tgt != '1))
        r_cnt_tgt <= r_cnt_tgt + CNT_W'(1);
    end
  end

  assign in_ready     = rst && w_free[0];
  assign out_valid    = r_v[LAST];
  assign out_rob_idx  = r_st[LAST].rob;
  assign out_rd_phys  = r_st[LAST].phys;
  assign out_rd_arch  = r_st[LAST].arch;
  assign out_data     = r_st[LAST].data;
  assign out_taken    = r_st[LAST].taken;
  assign out_miss     = r_st[LAST].miss;
  assign out_target   = r_st[LAST].target;
  assign cnt_resolved = r_cnt_res;
  assign cnt_miss     = r_cnt_miss;
  assign cnt_tgt_miss = r_cnt_tgt;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: directed scenarios plus randomized traffic, all checked
// against a queue-based reference of in-flight branches and saturating counters.
module tb_br_resolve_unit;
  localparam int unsigned RW = 5, PW = 6, DEPTH = 2;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, in_pred_taken, kill_valid, flush, out_valid, out_ready;
  logic [RW-1:0] in_rob_idx, rob_head, kill_rob_idx, out_rob_idx;
  logic [PW-1:0] in_rd_phys, out_rd_phys;
  logic [4:0] in_rd_arch, out_rd_arch;
  logic [6:0] in_opcode;
  logic [2:0] in_funct3;
  logic [31:0] in_pc, in_rs1_v, in_rs2_v, in_imm, in_pred_target, out_data, out_target;
  logic out_taken, out_miss, cnt_clear;
  logic [31:0] cnt_resolved, cnt_miss, cnt_tgt_miss;
  logic c2_in_ready, c2_out_valid, c2_out_taken, c2_out_miss;
  logic [RW-1:0] c2_out_rob_idx;
  logic [PW-1:0] c2_out_rd_phys;
  logic [4:0] c2_out_rd_arch;
  logic [31:0] c2_out_data, c2_out_target;
  logic [1:0] c2_cnt_resolved, c2_cnt_miss, c2_cnt_tgt_miss;

  br_resolve_unit #(.XLEN(32), .ROB_IDX_W(RW), .PHYS_W(PW), .DEPTH(DEPTH), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rob_idx(in_rob_idx), .in_rd_phys(in_rd_phys), .in_rd_arch(in_rd_arch),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1_v(in_rs1_v),
    .in_rs2_v(in_rs2_v), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .rob_head(rob_head), .kill_valid(kill_valid),
    .kill_rob_idx(kill_rob_idx), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rob_idx(out_rob_idx), .out_rd_phys(out_rd_phys), .out_rd_arch(out_rd_arch),
    .out_data(out_data), .out_taken(out_taken), .out_miss(out_miss), .out_target(out_target),
    .cnt_clear(cnt_clear), .cnt_resolved(cnt_resolved), .cnt_miss(cnt_miss),
    .cnt_tgt_miss(cnt_tgt_miss));

  br_resolve_unit #(.XLEN(32), .ROB_IDX_W(RW), .PHYS_W(PW), .DEPTH(DEPTH), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready),
    .in_rob_idx(in_rob_idx), .in_rd_phys(in_rd_phys), .in_rd_arch(in_rd_arch),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1_v(in_rs1_v),
    .in_rs2_v(in_rs2_v), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .rob_head(rob_head), .kill_valid(kill_valid),
    .kill_rob_idx(kill_rob_idx), .flush(flush), .out_valid(c2_out_valid), .out_ready(out_ready),
    .out_rob_idx(c2_out_rob_idx), .out_rd_phys(c2_out_rd_phys), .out_rd_arch(c2_out_rd_arch),
    .out_data(c2_out_data), .out_taken(c2_out_taken), .out_miss(c2_out_miss),
    .out_target(c2_out_target), .cnt_clear(cnt_clear), .cnt_resolved(c2_cnt_resolved),
    .cnt_miss(c2_cnt_miss), .cnt_tgt_miss(c2_cnt_tgt_miss));

  typedef struct {
    logic [RW-1:0] rob;
    logic [PW-1:0] phys;
    logic [4:0]    arch;
    logic [31:0]   data, target;
    logic          taken, miss, pred;
    int            acc;
  } ent_t;

  ent_t q[$];
  logic [RW-1:0] obs[$];
  longint m_res, m_miss, m_tgt, m2_res, m2_miss, m2_tgt;
  int m_e, n_checks, n_errors;
  logic [RW-1:0] next_rob;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Architectural outcome of the instruction currently on the issue port.
  function automatic ent_t model_result();
    ent_t r;
    logic t;
    r = '{default: '0};
    r.rob = in_rob_idx; r.phys = in_rd_phys; r.arch = in_rd_arch;
    r.pred = in_pred_taken; r.acc = m_e;
    if (in_opcode == JAL || in_opcode == JALR) begin
      r.taken = 1'b1;
      r.data = in_pc + 32'd4;
      r.target = (in_opcode == JAL) ? in_pc + in_imm : (in_rs1_v + in_imm) & 32'hFFFF_FFFE;
      r.miss = !in_pred_taken || (in_pred_target != r.target);
    end else begin
      case (in_funct3)
        3'd0: t = (in_rs1_v == in_rs2_v);
        3'd1: t = (in_rs1_v != in_rs2_v);
        3'd4: t = ($signed(in_rs1_v) < $signed(in_rs2_v));
        3'd5: t = ($signed(in_rs1_v) >= $signed(in_rs2_v));
        3'd6: t = (in_rs1_v < in_rs2_v);
        3'd7: t = (in_rs1_v >= in_rs2_v);
        default: t = 1'b0;
      endcase
      r.taken = t;
      r.target = t ? in_pc + in_imm : in_pc + 32'd4;
      r.miss = (t != in_pred_taken) || (t && (in_pred_target != r.target));
    end
    return r;
  endfunction

  function automatic bit younger(input logic [RW-1:0] x, input logic [RW-1:0] ref_idx);
    logic [RW-1:0] ax, ar;
    ax = x - rob_head;
    ar = ref_idx - rob_head;
    return ax > ar;
  endfunction

  function automatic bit squashed(input logic [RW-1:0] x, input bit sk, input logic [RW-1:0] sref);
    return (kill_valid && younger(x, kill_rob_idx)) || (sk && younger(x, sref));
  endfunction

  // Bubbles are always squeezed out, so the oldest entry reaches the output DEPTH-1 edges after entry.
  function automatic bit exp_ov();
    return (q.size() > 0) && ((m_e - 1 - q[0].acc) >= int'(DEPTH) - 1);
  endfunction

  task automatic model_check();
    bit ov;
    ov = exp_ov();
    chk("in_ready", in_ready, rst && (out_ready || q.size() < DEPTH));
    chk("c2_in_ready", c2_in_ready, rst && (out_ready || q.size() < DEPTH));
    chk("out_valid", out_valid, ov);
    chk("c2_out_valid", c2_out_valid, ov);
    if (ov) begin
      chk("out_rob_idx", out_rob_idx, q[0].rob);
      chk("out_rd_phys", out_rd_phys, q[0].phys);
      chk("out_rd_arch", out_rd_arch, q[0].arch);
      chk("out_data", out_data, q[0].data);
      chk("out_taken", out_taken, q[0].taken);
      chk("out_miss", out_miss, q[0].miss);
      chk("out_target", out_target, q[0].target);
      chk("c2_tag", {c2_out_rob_idx, c2_out_rd_phys, c2_out_rd_arch, c2_out_taken, c2_out_miss},
          {q[0].rob, q[0].phys, q[0].arch, q[0].taken, q[0].miss});
      chk("c2_data_tgt", {c2_out_data, c2_out_target}, {q[0].data, q[0].target});
    end
    chk("cnt_resolved", cnt_resolved, m_res);
    chk("cnt_miss", cnt_miss, m_miss);
    chk("cnt_tgt_miss", cnt_tgt_miss, m_tgt);
    chk("c2_cnts", {c2_cnt_resolved, c2_cnt_miss, c2_cnt_tgt_miss},
        {m2_res[1:0], m2_miss[1:0], m2_tgt[1:0]});
    if (out_valid && out_ready) obs.push_back(out_rob_idx);
  endtask

  task automatic model_update();
    bit hs, acc, sk;
    logic [RW-1:0] sref;
    ent_t keep[$];
    if (!rst) begin
      q.delete();
      m_res = 0; m_miss = 0; m_tgt = 0; m2_res = 0; m2_miss = 0; m2_tgt = 0;
      m_e++;
      return;
    end
    hs = exp_ov() && out_ready;
    acc = in_valid && (out_ready || q.size() < DEPTH);
    sk = 1'b0;
    sref = '0;
    if (hs) begin
      sk = q[0].miss;
      sref = q[0].rob;
      m_res = sat(m_res, MAX32); m2_res = sat(m2_res, 3);
      if (q[0].miss) begin m_miss = sat(m_miss, MAX32); m2_miss = sat(m2_miss, 3); end
      if (q[0].miss && q[0].taken && q[0].pred) begin
        m_tgt = sat(m_tgt, MAX32); m2_tgt = sat(m2_tgt, 3);
      end
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else begin
      foreach (q[i]) if (!squashed(q[i].rob, sk, sref)) keep.push_back(q[i]);
      q = keep;
    end
    if (acc) begin
      if ((in_opcode == JAL || in_opcode == JALR || in_opcode == BR) && !flush
          && !squashed(in_rob_idx, sk, sref))
        q.push_back(model_result());
      next_rob++;
    end
    if (cnt_clear) begin
      m_res = 0; m_miss = 0; m_tgt = 0; m2_res = 0; m2_miss = 0; m2_tgt = 0;
    end
    m_e++;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; kill_valid = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                           input logic pt, input logic [31:0] ptgt, input logic [RW-1:0] rob);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_pc = pc;
    in_rs1_v = rs1; in_rs2_v = rs2; in_imm = imm;
    in_pred_taken = pt; in_pred_target = ptgt; in_rob_idx = rob;
    in_rd_phys = PW'(rob) + PW'(7); in_rd_arch = rob ^ 5'h15;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int k;
    logic [11:0] r12;
    ent_t c;
    n_checks = 0; n_errors = 0; m_e = 0; next_rob = '0;
    m_res = 0; m_miss = 0; m_tgt = 0; m2_res = 0; m2_miss = 0; m2_tgt = 0;
    rst = 1'b0; out_ready = 1'b0; rob_head = '0; kill_rob_idx = '0;
    idle();
    set_instr(JAL, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cnt", {cnt_resolved, cnt_miss}, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    step();

    // BEQ taken, correctly predicted
    rob_head = 0;
    set_instr(BR, 3'b000, 32'h100, 5, 5, 32'h20, 1, 32'h120, 0);
    step(); idle();
    chk("beq_cycle1_valid", out_valid, 0);
    step();
    chk("beq_cycle2_valid", out_valid, 1);
    chk("beq_taken", out_taken, 1);
    chk("beq_target", out_target, 32'h120);
    chk("beq_miss", out_miss, 0);
    step();
    chk("beq_cnt_resolved", cnt_resolved, 1);

    // JALR target mismatch
    rob_head = 1;
    set_instr(JALR, 3'b000, 32'h40, 32'h203, 0, 0, 1, 32'h200, 1);
    step(); idle(); step();
    chk("jalr_target", out_target, 32'h202);
    chk("jalr_data", out_data, 32'h44);
    chk("jalr_miss", out_miss, 1);
    step();
    chk("jalr_cnt_miss", cnt_miss, 1);
    chk("jalr_cnt_tgt_miss", cnt_tgt_miss, 1);

    // Mispredicted BLT squashes the two younger entries behind it
    rob_head = 3; obs.delete();
    set_instr(BR, 3'b100, 32'h300, 32'hFFFF_FFFF, 1, 32'h40, 0, 32'h304, 3); step();
    set_instr(JAL, 0, 32'h304, 0, 0, 8, 1, 32'h30C, 4); step();
    set_instr(JAL, 0, 32'h308, 0, 0, 8, 1, 32'h310, 5); step();
    idle();
    repeat (4) step();
    chk("selfkill_count", obs.size(), 1);
    if (obs.size() > 0) chk("selfkill_rob", obs[0], 3);
    chk("selfkill_cnt_miss", cnt_miss, 2);

    // Backpressure: four issues with out_ready held low, then released
    rob_head = 10; obs.delete(); k = 0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      out_ready = (cyc >= 5);
      set_instr(JAL, 0, 32'h1000 + 32'(k) * 4, 0, 0, 16, 1, 32'h1010 + 32'(k) * 4, RW'(10 + k));
      #1;
      if (cyc == 4) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_rob", out_rob_idx, 10);
        chk("bp_hold_target", out_target, 32'h1010);
      end
      if (in_ready) begin
        step();
        k++;
      end else step();
    end
    chk("bp_all_accepted", k, 4);
    idle(); out_ready = 1'b1;
    repeat (5) step();
    chk("bp_out_count", obs.size(), 4);
    foreach (obs[i]) chk("bp_order", obs[i], 10 + i);

    // Wrap-around external kill
    rob_head = 30; obs.delete();
    set_instr(JAL, 0, 32'h2000, 0, 0, 4, 1, 32'h2004, 31); step();
    set_instr(JAL, 0, 32'h2004, 0, 0, 4, 1, 32'h2008, 0); step();
    set_instr(JAL, 0, 32'h2008, 0, 0, 4, 1, 32'h200C, 1);
    kill_valid = 1'b1; kill_rob_idx = 31;
    step(); idle();
    repeat (4) step();
    chk("wrap_count", obs.size(), 1);
    if (obs.size() > 0) chk("wrap_rob", obs[0], 31);

    // Clear concurrent with a handshake
    rob_head = 2;
    set_instr(JAL, 0, 32'h80, 0, 0, 4, 1, 32'h84, 2); step(); idle(); step();
    cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
    chk("clear_cnt_resolved", cnt_resolved, 0);
    chk("clear_c2_resolved", c2_cnt_resolved, 0);

    // Five resolutions saturate the 2-bit counter
    rob_head = 0;
    for (int i = 0; i < 5; i++) begin
      set_instr(JAL, 0, 32'h500, 0, 0, 4, 1, 32'h504, RW'(i));
      step();
    end
    idle();
    repeat (3) step();
    chk("sat_cnt_resolved", cnt_resolved, 5);
    chk("sat_c2_resolved", c2_cnt_resolved, 3);

    // Reset with entries in flight
    out_ready = 1'b0;
    set_instr(JAL, 0, 32'h600, 0, 0, 4, 1, 32'h604, 5); step();
    set_instr(JAL, 0, 32'h604, 0, 0, 4, 1, 32'h608, 6); step();
    idle(); rst = 1'b0; step(); rst = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cnt", cnt_resolved, 0);

    // Randomized traffic with ROB indices issued in program order
    next_rob = 7;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      kill_valid = ($urandom_range(0, 19) == 0);
      kill_rob_idx = next_rob - RW'($urandom_range(1, 3));
      cnt_clear = ($urandom_range(0, 99) == 0);
      rob_head = ((q.size() > 0) ? q[0].rob : next_rob) - RW'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0: in_opcode = JAL;
        1: in_opcode = JALR;
        5: in_opcode = 7'b0110011;
        default: in_opcode = BR;
      endcase
      r12 = 12'($urandom);
      set_instr(in_opcode, 3'($urandom), $urandom & 32'hFFFF_FFFC, pick_val(), pick_val(),
                {{20{r12[11]}}, r12}, 1'($urandom), 0, next_rob);
      in_valid = ($urandom_range(0, 3) != 0);
      c = model_result();
      in_pred_target = $urandom_range(0, 1) ? c.target : $urandom;
      step();
    end
    idle(); rst = 1'b1; out_ready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
